// File: rtl/crc32_fcs_checker.sv
// Receive-side Ethernet FCS checker: CRC32 residue and length check over data+FCS words.
// Optional per-outcome frame counters are built when CRC_CHK_STATS_EN is defined.
module crc32_fcs_checker #(
  parameter logic [31:0] CRC_INIT        = 32'hFFFFFFFF,
  parameter logic [31:0] CRC_RESIDUE     = 32'hDEBB20E3,
  parameter int          MIN_FRAME_BYTES = 64,
  parameter int          MAX_FRAME_BYTES = 1522
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        start_of_packet,
  input  logic        last_word,
  input  logic [1:0]  last_bytes,
  input  logic [31:0] data_in,
  output logic        valid_out,
  output logic        crc_ok,
  output logic        len_err,
  output logic        abort_err,
  output logic [15:0] frame_len
`ifdef CRC_CHK_STATS_EN
  ,
  output logic [31:0] good_frames,
  output logic [31:0] bad_crc_frames,
  output logic [31:0] len_err_frames,
  output logic [31:0] abort_frames
`endif
);

  localparam logic [31:0] POLY = 32'hEDB88320;

  typedef enum logic {S_IDLE, S_FRAME} state_t;

  function automatic logic [31:0] crc_update(input logic [31:0] crc, input logic [31:0] data,
                                             input logic [2:0] nbytes);
    logic [31:0] c;
    c = crc;
    for (int b = 0; b < 4; b++) begin
      if (3'(b) < nbytes) begin
        c = c ^ {24'd0, data[8*b +: 8]};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
      end
    end
    return c;
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [2:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {14'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic len_bad(input logic [15:0] len);
    return (int'(len) < MIN_FRAME_BYTES) || (int'(len) > MAX_FRAME_BYTES);
  endfunction

  logic        r_en_p0, r_sop_p0, r_last_p0;
  logic [1:0]  r_lb_p0;
  logic [31:0] r_data_p0;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_lfsr;
  logic [15:0] r_cnt;

  logic        r_rec_vld_p1, r_rec_ok_p1, r_rec_lerr_p1, r_rec_abort_p1;
  logic [15:0] r_rec_len_p1;
  logic        r_def_vld, r_def_ok, r_def_lerr;
  logic [15:0] r_def_len;

  logic        r_vld_p2, r_ok_p2, r_lerr_p2, r_abort_p2;
  logic [15:0] r_len_p2;

  logic [2:0]  w_nb;
  logic [31:0] w_crc;
  logic [15:0] w_cnt;
  logic        w_upd, w_rec_vld, w_rec_ok, w_rec_lerr, w_rec_abort;
  logic [15:0] w_rec_len;
  logic        w_def_vld;

  // Stage 1: input register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_en_p0   <= 1'b0;
      r_sop_p0  <= 1'b0;
      r_last_p0 <= 1'b0;
      r_lb_p0   <= 2'd0;
      r_data_p0 <= 32'd0;
    end else begin
      r_en_p0   <= enable;
      r_sop_p0  <= start_of_packet;
      r_last_p0 <= last_word;
      r_lb_p0   <= last_bytes;
      r_data_p0 <= enable ? data_in : 32'd0;
    end
  end

  // Stage 2: CRC/length update and frame FSM
  assign w_nb  = (r_last_p0 && r_lb_p0 != 2'd0) ? {1'b0, r_lb_p0} : 3'd4;
  assign w_crc = crc_update(r_sop_p0 ? CRC_INIT : r_lfsr, r_data_p0, w_nb);
  assign w_cnt = sat_add(r_sop_p0 ? 16'd0 : r_cnt, w_nb);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_upd       = 1'b0;
    w_rec_vld   = 1'b0;
    w_rec_ok    = 1'b0;
    w_rec_lerr  = 1'b0;
    w_rec_abort = 1'b0;
    w_rec_len   = 16'd0;
    w_def_vld   = 1'b0;
    if (r_en_p0) begin
      case (r_state)
        S_IDLE: begin
          if (r_sop_p0) begin
            w_upd = 1'b1;
            if (r_last_p0) begin
              w_rec_vld  = 1'b1;
              w_rec_ok   = (w_crc == CRC_RESIDUE);
              w_rec_lerr = len_bad(w_cnt);
              w_rec_len  = w_cnt;
            end else begin
              w_state_nxt = S_FRAME;
            end
          end
        end
        default: begin
          w_upd = 1'b1;
          if (r_sop_p0) begin
            // Abort: old frame reports now; a same-word single-word frame waits one cycle.
            w_rec_vld   = 1'b1;
            w_rec_abort = 1'b1;
            w_rec_len   = r_cnt;
            w_def_vld   = r_last_p0;
          end else if (r_last_p0) begin
            w_rec_vld  = 1'b1;
            w_rec_ok   = (w_crc == CRC_RESIDUE);
            w_rec_lerr = len_bad(w_cnt);
            w_rec_len  = w_cnt;
          end
          if (r_last_p0) w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr         <= CRC_INIT;
      r_cnt          <= 16'd0;
      r_rec_vld_p1   <= 1'b0;
      r_rec_ok_p1    <= 1'b0;
      r_rec_lerr_p1  <= 1'b0;
      r_rec_abort_p1 <= 1'b0;
      r_rec_len_p1   <= 16'd0;
      r_def_vld      <= 1'b0;
      r_def_ok       <= 1'b0;
      r_def_lerr     <= 1'b0;
      r_def_len      <= 16'd0;
    end else begin
      if (w_upd) begin
        r_lfsr <= w_crc;
        r_cnt  <= w_cnt;
      end
      r_def_vld  <= w_def_vld;
      r_def_ok   <= (w_crc == CRC_RESIDUE);
      r_def_lerr <= len_bad(w_cnt);
      r_def_len  <= w_cnt;
      r_rec_vld_p1 <= r_def_vld | w_rec_vld;
      if (r_def_vld) begin
        r_rec_ok_p1    <= r_def_ok;
        r_rec_lerr_p1  <= r_def_lerr;
        r_rec_abort_p1 <= 1'b0;
        r_rec_len_p1   <= r_def_len;
      end else begin
        r_rec_ok_p1    <= w_rec_ok;
        r_rec_lerr_p1  <= w_rec_lerr;
        r_rec_abort_p1 <= w_rec_abort;
        r_rec_len_p1   <= w_rec_len;
      end
    end
  end

  // Stage 3: registered status record, held until the next one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld_p2   <= 1'b0;
      r_ok_p2    <= 1'b0;
      r_lerr_p2  <= 1'b0;
      r_abort_p2 <= 1'b0;
      r_len_p2   <= 16'd0;
    end else begin
      r_vld_p2 <= r_rec_vld_p1;
      if (r_rec_vld_p1) begin
        r_ok_p2    <= r_rec_ok_p1;
        r_lerr_p2  <= r_rec_lerr_p1;
        r_abort_p2 <= r_rec_abort_p1;
        r_len_p2   <= r_rec_len_p1;
      end
    end
  end

  assign valid_out = r_vld_p2;
  assign crc_ok    = r_ok_p2;
  assign len_err   = r_lerr_p2;
  assign abort_err = r_abort_p2;
  assign frame_len = r_len_p2;

`ifdef CRC_CHK_STATS_EN
  logic [31:0] r_good, r_bad_crc, r_len_errs, r_aborts;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_good     <= 32'd0;
      r_bad_crc  <= 32'd0;
      r_len_errs <= 32'd0;
      r_aborts   <= 32'd0;
    end else if (r_vld_p2) begin
      if (r_ok_p2 && !r_lerr_p2 && !r_abort_p2) r_good <= r_good + 32'd1;
      if (!r_ok_p2)   r_bad_crc  <= r_bad_crc + 32'd1;
      if (r_lerr_p2)  r_len_errs <= r_len_errs + 32'd1;
      if (r_abort_p2) r_aborts   <= r_aborts + 32'd1;
    end
  end

  assign good_frames    = r_good;
  assign bad_crc_frames = r_bad_crc;
  assign len_err_frames = r_len_errs;
  assign abort_frames   = r_aborts;
`endif

  always @(posedge clk) begin
    if (reset_n && !enable)
      assert (!(start_of_packet || last_word))
        else $error("start_of_packet/last_word asserted without enable");
  end

endmodule

// File: tb/tb_crc32_fcs_checker.sv
// Directed bench for crc32_fcs_checker: two instances (MIN_FRAME_BYTES=1 and default)
// checked every cycle against a frame-level byte-queue model.
module tb_crc32_fcs_checker;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0, sop = 1'b0, last = 1'b0;
  logic [1:0]  lb = 2'd0;
  logic [31:0] din = 32'd0;

  logic        va, oka, lea, aba, vb, okb, leb, abb;
  logic [15:0] lna, lnb;
`ifdef CRC_CHK_STATS_EN
  logic [31:0] ga, bca, lca, aca, gb, bcb, lcb, acb;
`endif

  crc32_fcs_checker #(.MIN_FRAME_BYTES(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .enable(enable), .start_of_packet(sop), .last_word(last),
    .last_bytes(lb), .data_in(din), .valid_out(va), .crc_ok(oka), .len_err(lea),
    .abort_err(aba), .frame_len(lna)
`ifdef CRC_CHK_STATS_EN
    , .good_frames(ga), .bad_crc_frames(bca), .len_err_frames(lca), .abort_frames(aca)
`endif
  );

  crc32_fcs_checker dut_b (
    .clk(clk), .reset_n(reset_n), .enable(enable), .start_of_packet(sop), .last_word(last),
    .last_bytes(lb), .data_in(din), .valid_out(vb), .crc_ok(okb), .len_err(leb),
    .abort_err(abb), .frame_len(lnb)
`ifdef CRC_CHK_STATS_EN
    , .good_frames(gb), .bad_crc_frames(bcb), .len_err_frames(lcb), .abort_frames(acb)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int cyc;
    bit ok;
    bit abort;
    int len;
    bit lerr;
  } rec_t;

  rec_t exp_q[$];
  rec_t loga[$];
  rec_t logb[$];
  bq_t  cur;
  int   cur_len = 0;
  bit   in_frame = 0;
  int   nchk = 0;
  int   nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference CRC: bit-serial over the whole byte stream, LSB of each byte first.
  function automatic logic [31:0] m_crc(input bq_t q);
    logic [31:0] r;
    logic fb;
    r = 32'hFFFFFFFF;
    foreach (q[i])
      for (int k = 0; k < 8; k++) begin
        fb = r[0] ^ q[i][k];
        r  = r >> 1;
        if (fb) r = r ^ 32'hEDB88320;
      end
    return r;
  endfunction

  function automatic bit m_lerr(input rec_t r, input int min_b);
    return !r.abort && (r.len < min_b || r.len > 1522);
  endfunction

  task automatic push_rec(input int t, input bit ok, input bit ab, input int len);
    rec_t r;
    r.cyc = t; r.ok = ok; r.abort = ab; r.len = len; r.lerr = 0;
    exp_q.push_back(r);
  endtask

  task automatic model_word(input bit s, input bit l, input logic [1:0] b,
                            input logic [31:0] d, input int t);
    int  nb;
    bit  aborted;
    nb = (l && b != 2'd0) ? int'(b) : 4;
    aborted = 0;
    if (!in_frame) begin
      if (!s) return;
    end else if (s) begin
      push_rec(t, 0, 1, cur_len);
      aborted = 1;
    end
    if (s) begin
      cur = {};
      cur_len = 0;
    end
    for (int i = 0; i < nb; i++) cur.push_back(d[8*i +: 8]);
    cur_len = (cur_len + nb > 65535) ? 65535 : cur_len + nb;
    if (l) begin
      push_rec(aborted ? t + 1 : t, m_crc(cur) == 32'hDEBB20E3, 0, cur_len);
      in_frame = 0;
    end else begin
      in_frame = 1;
    end
  endtask

  // Inputs change 1 time unit after a rising edge; they are sampled on the next edge,
  // so a last word driven while cyc==k reports at cyc==k+3.
  task automatic drive(input bit e, input bit s, input bit l, input logic [1:0] b,
                       input logic [31:0] d);
    @(posedge clk);
    #1;
    enable = e; sop = s; last = l; lb = b; din = d;
    if (e) model_word(s, l, b, d, cyc + 3);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 2'd0, 32'd0);
  endtask

  task automatic send_s1(input bit corrupt, input int gap);
    drive(1, 1, 0, 2'd0, 32'h34333231); idle(gap);
    drive(1, 0, 0, 2'd0, 32'h38373635); idle(gap);
    drive(1, 0, 0, 2'd0, corrupt ? 32'hF4392638 : 32'hF4392639); idle(gap);
    drive(1, 0, 1, 2'd1, 32'h000000CB);
    idle(6);
  endtask

  task automatic monitor();
    bit   ev;
    rec_t r;
    rec_t g;
    forever begin
      @(negedge clk);
      ev = (exp_q.size() != 0) && (exp_q[0].cyc == cyc);
      if (ev) r = exp_q.pop_front();
      chk("a_valid", 32'(va), 32'(ev));
      chk("b_valid", 32'(vb), 32'(ev));
      if (ev) begin
        chk("a_crc_ok", 32'(oka), 32'(r.ok));
        chk("a_abort",  32'(aba), 32'(r.abort));
        chk("a_len",    32'(lna), 32'(r.len));
        chk("a_lerr",   32'(lea), 32'(m_lerr(r, 1)));
        chk("b_crc_ok", 32'(okb), 32'(r.ok));
        chk("b_abort",  32'(abb), 32'(r.abort));
        chk("b_len",    32'(lnb), 32'(r.len));
        chk("b_lerr",   32'(leb), 32'(m_lerr(r, 64)));
      end
      if (va) begin
        g.cyc = cyc; g.ok = oka; g.abort = aba; g.len = int'(lna); g.lerr = lea;
        loga.push_back(g);
      end
      if (vb) begin
        g.cyc = cyc; g.ok = okb; g.abort = abb; g.len = int'(lnb); g.lerr = leb;
        logb.push_back(g);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, nchk=%0d", nchk);
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t t9;
    int  n0;
    fork
      monitor();
    join_none

    // Pin the reference model itself
    t9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    chk("model_check_value", ~m_crc(t9), 32'hCBF43926);
    t9.push_back(8'h26); t9.push_back(8'h39); t9.push_back(8'hF4); t9.push_back(8'hCB);
    chk("model_residue", m_crc(t9), 32'hDEBB20E3);

    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", 32'(va), 32'd0);
    chk("rst_crc_ok", 32'(oka), 32'd0);
    chk("rst_len_err", 32'(lea), 32'd0);
    chk("rst_abort", 32'(aba), 32'd0);
    chk("rst_frame_len", 32'(lna), 32'd0);

    // Good frame, MIN=1 instance passes and default instance flags length
    n0 = loga.size();
    send_s1(0, 0);
    chk("t1_recs", 32'(loga.size() - n0), 32'd1);
    chk("t1_crc_ok", 32'(loga[$].ok), 32'd1);
    chk("t1_len", 32'(loga[$].len), 32'd13);
    chk("t1_lerr", 32'(loga[$].lerr), 32'd0);
    chk("t3_small_lerr", 32'(logb[$].lerr), 32'd1);
    chk("t3_small_ok", 32'(logb[$].ok), 32'd1);

    // Corrupt FCS
    send_s1(1, 0);
    chk("t2_crc_ok", 32'(loga[$].ok), 32'd0);
    chk("t2_len", 32'(loga[$].len), 32'd13);

    // Oversize frame
    drive(1, 1, 0, 2'd0, $urandom);
    for (int i = 0; i < 398; i++) drive(1, 0, 0, 2'd0, $urandom);
    drive(1, 0, 1, 2'd0, $urandom);
    idle(6);
    chk("t3_big_len", 32'(loga[$].len), 32'd1600);
    chk("t3_big_lerr_a", 32'(loga[$].lerr), 32'd1);
    chk("t3_big_lerr_b", 32'(logb[$].lerr), 32'd1);

    // Abort by a new start_of_packet
    n0 = loga.size();
    drive(1, 1, 0, 2'd0, 32'h11111111);
    drive(1, 0, 0, 2'd0, 32'h22222222);
    drive(1, 0, 0, 2'd0, 32'h33333333);
    send_s1(0, 0);
    chk("t4_recs", 32'(loga.size() - n0), 32'd2);
    chk("t4_abort", 32'(loga[n0].abort), 32'd1);
    chk("t4_abort_len", 32'(loga[n0].len), 32'd12);
    chk("t4_abort_ok", 32'(loga[n0].ok), 32'd0);
    chk("t4_next_ok", 32'(loga[n0+1].ok), 32'd1);
    chk("t4_next_len", 32'(loga[n0+1].len), 32'd13);

    // Abort by a single-word frame: two records on consecutive cycles
    n0 = loga.size();
    drive(1, 1, 0, 2'd0, 32'hA5A5A5A5);
    drive(1, 0, 0, 2'd0, 32'h5A5A5A5A);
    drive(1, 1, 1, 2'd2, 32'h0000BBAA);
    idle(6);
    chk("t4b_recs", 32'(loga.size() - n0), 32'd2);
    chk("t4b_abort_len", 32'(loga[n0].len), 32'd8);
    chk("t4b_spacing", 32'(loga[n0+1].cyc - loga[n0].cyc), 32'd1);
    chk("t4b_single_len", 32'(loga[n0+1].len), 32'd2);

    // Single-word frame from IDLE
    drive(1, 1, 1, 2'd3, 32'h00ABCDEF);
    idle(6);
    chk("single_len", 32'(logb[$].len), 32'd3);
    chk("single_lerr_b", 32'(logb[$].lerr), 32'd1);

    // Gaps between words
    n0 = loga.size();
    send_s1(0, 5);
    chk("t5_gap_recs", 32'(loga.size() - n0), 32'd1);
    chk("t5_gap_ok", 32'(loga[$].ok), 32'd1);
    chk("t5_gap_len", 32'(loga[$].len), 32'd13);

    // Orphan words in IDLE
    n0 = loga.size();
    drive(1, 0, 0, 2'd0, 32'hDEADBEEF);
    drive(1, 0, 1, 2'd0, 32'hCAFEF00D);
    idle(6);
    chk("t5_orphan_recs", 32'(loga.size() - n0), 32'd0);

    // Reset mid-frame, then resend
    drive(1, 1, 0, 2'd0, 32'h34333231);
    drive(1, 0, 0, 2'd0, 32'h38373635);
    @(posedge clk);
    #1;
    enable = 1'b0; sop = 1'b0; last = 1'b0;
    reset_n = 1'b0;
    in_frame = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("t6_rst_len", 32'(lna), 32'd0);
    n0 = loga.size();
    send_s1(0, 0);
    chk("t6_recs", 32'(loga.size() - n0), 32'd1);
    chk("t6_ok", 32'(loga[$].ok), 32'd1);
`ifdef CRC_CHK_STATS_EN
    chk("t6_good_a", ga, 32'd1);
    chk("t6_bad_a", bca, 32'd0);
    chk("t6_good_b", gb, 32'd0);
    chk("t6_lerr_b", lcb, 32'd1);
    chk("t6_abort_b", acb, 32'd0);
`endif

    idle(4);
    chk("pending_records", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
